// File: rtl/arm_pipelined_skid_stage.sv
// arm_pipelined_skid_stage
//   Elastic valid/ready pipeline stage with a two-entry skid buffer.
//   Upstream ready (o_Ready) is decoded from registered state only, so
//   downstream ready never reaches it combinationally.
//   A synchronous flush drops everything held and anything handed over
//   in the same cycle.
//
//   Optional feature macro: ARM_PIPELINED_SKID_STATS_EN
//     defined   -> o_StallCount counts cycles with o_Valid=1 and i_Ready=0,
//                  saturating at all-ones and cleared only by reset.
//     undefined -> o_StallCount is tied to 0.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   i_Valid/o_Ready    upstream handshake, i_Data payload in
//   o_Valid/i_Ready    downstream handshake, o_Data payload out
//   i_Flush            discard held and incoming payloads
//   o_Occupancy        held entries: 0, 1 or 2
//   o_StallCount       downstream stall cycle counter
module arm_pipelined_skid_stage #(
  parameter int BusWidth        = 32,
  parameter int StallCountWidth = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_Valid,
  output logic                       o_Ready,
  input  logic [BusWidth-1:0]        i_Data,
  output logic                       o_Valid,
  input  logic                       i_Ready,
  output logic [BusWidth-1:0]        o_Data,
  input  logic                       i_Flush,
  output logic [1:0]                 o_Occupancy,
  output logic [StallCountWidth-1:0] o_StallCount
);

  // Encodings equal the occupancy so it can be read straight off the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BusWidth-1:0] main_q, main_d;
  logic [BusWidth-1:0] skid_q, skid_d;
  logic                in_fire, out_fire;

  assign o_Valid     = (state_q != EMPTY);
  assign o_Ready     = (state_q != FULL);
  assign o_Data      = main_q;
  assign o_Occupancy = state_q;

  assign in_fire  = i_Valid & o_Ready;
  assign out_fire = o_Valid & i_Ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = i_Data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = i_Data;
        end else if (in_fire) begin
          // Downstream stalled after we advertised ready: park in skid.
          skid_d  = i_Data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // o_Ready is low here, so only the drain side can move.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || i_Flush) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef ARM_PIPELINED_SKID_STATS_EN
  logic [StallCountWidth-1:0] stall_q;

  // Flush does not clear the counter; it keeps counting through a flush cycle.
  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= '0;
    else if (o_Valid && !i_Ready && (stall_q != {StallCountWidth{1'b1}}))
      stall_q <= stall_q + 1'b1;
  end

  assign o_StallCount = stall_q;
`else
  assign o_StallCount = '0;
`endif

endmodule

// File: tb/tb_arm_pipelined_skid_stage.sv
module tb_arm_pipelined_skid_stage;
  localparam int BW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_Valid;
  logic          o_Ready;
  logic [BW-1:0] i_Data;
  logic          o_Valid;
  logic          i_Ready;
  logic [BW-1:0] o_Data;
  logic          i_Flush;
  logic [1:0]    o_Occupancy;
  logic [SW-1:0] o_StallCount;

  int total = 0;
  int bad   = 0;
  int popped = 0;
  logic [BW-1:0] sb[$];

  arm_pipelined_skid_stage #(.BusWidth(BW), .StallCountWidth(SW)) dut (
    .clk(clk), .reset(reset), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Data(i_Data), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Data(o_Data),
    .i_Flush(i_Flush), .o_Occupancy(o_Occupancy), .o_StallCount(o_StallCount)
  );

  always #5 clk = ~clk;

  // One clock: check outputs against the scoreboard, update it from the
  // inputs that will be sampled at the coming edge, then advance past it.
  task automatic cycle();
    logic [BW-1:0] exp;
    if (!reset) begin
      total++;
      if (o_Occupancy !== 2'(sb.size())) begin
        bad++; $display("FAIL occupancy: got %0d want %0d", o_Occupancy, sb.size());
      end
      total++;
      if (o_Ready !== (sb.size() != 2)) begin
        bad++; $display("FAIL ready: got %b want %b", o_Ready, sb.size() != 2);
      end
      total++;
      if (o_Valid !== (sb.size() != 0)) begin
        bad++; $display("FAIL valid: got %b want %b", o_Valid, sb.size() != 0);
      end
    end
    if (reset || i_Flush) begin
      sb.delete();
    end else begin
      if (o_Valid === 1'b1 && i_Ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL sb_unexpected: got data %h want none", o_Data);
        end else begin
          exp = sb.pop_front();
          popped++;
          if (o_Data !== exp) begin
            bad++; $display("FAIL sb_data: got %h want %h", o_Data, exp);
          end
        end
      end
      if (i_Valid && o_Ready === 1'b1) sb.push_back(i_Data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_Valid = 0; i_Flush = 0; i_Data = '0;
  endtask

  task automatic test_reset();
    reset = 1; i_Ready = 0; idle();
    cycle(); cycle();
    reset = 0;
    total++;
    if (o_Valid !== 0 || o_Ready !== 1 || o_Data !== '0 || o_Occupancy !== 0 || o_StallCount !== '0) begin
      bad++; $display("FAIL reset_vals: got v=%b r=%b d=%h occ=%0d sc=%0d want 0 1 00 0 0",
                      o_Valid, o_Ready, o_Data, o_Occupancy, o_StallCount);
    end
  endtask

  task automatic test_stream();
    logic [BW-1:0] pl [3];
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    i_Ready = 1;
    for (int k = 0; k < 3; k++) begin
      i_Valid = 1; i_Data = pl[k];
      cycle();
      total++;
      if (o_Valid !== 1 || o_Data !== pl[k]) begin
        bad++; $display("FAIL stream_latency: got v=%b d=%h want 1 %h", o_Valid, o_Data, pl[k]);
      end
      total++;
      if (o_Ready !== 1 || o_Occupancy !== 1) begin
        bad++; $display("FAIL stream_occ: got r=%b occ=%0d want 1 1", o_Ready, o_Occupancy);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_backpressure();
    int base;
    int n;
    logic [BW-1:0] nxt;
    base = popped;
    i_Ready = 1; i_Valid = 1; i_Data = 8'hA0;
    cycle();
    i_Ready = 0; i_Data = 8'hA1;
    cycle();
    total++;
    if (o_Ready !== 0 || o_Occupancy !== 2) begin
      bad++; $display("FAIL bp_full: got r=%b occ=%0d want 0 2", o_Ready, o_Occupancy);
    end
    i_Data = 8'hA2;
    cycle(); cycle();
    total++;
    if (o_Data !== 8'hA0 || o_Occupancy !== 2) begin
      bad++; $display("FAIL bp_hold: got d=%h occ=%0d want a0 2", o_Data, o_Occupancy);
    end
    i_Ready = 1;
    n = 0;
    while ((i_Valid || sb.size() != 0) && n < 20) begin
      nxt = (i_Valid && o_Ready) ? 8'h00 : i_Data;
      if (i_Valid && o_Ready) begin
        cycle(); idle();
      end else begin
        i_Data = nxt; cycle();
      end
      n++;
    end
    total++;
    if (n >= 20 || popped - base != 3) begin
      bad++; $display("FAIL bp_drain: got %0d payloads in %0d cycles want 3", popped - base, n);
    end
  endtask

  task automatic test_flush();
    // Flush while FULL with a payload offered.
    i_Ready = 0; i_Valid = 1; i_Data = 8'hB0;
    cycle(); i_Data = 8'hB1;
    cycle();
    i_Flush = 1; i_Ready = 1; i_Data = 8'hFF;
    cycle();
    idle();
    total++;
    if (o_Valid !== 0 || o_Occupancy !== 0 || o_Data !== '0) begin
      bad++; $display("FAIL flush_full: got v=%b occ=%0d d=%h want 0 0 00", o_Valid, o_Occupancy, o_Data);
    end
    // Flush while BUSY: o_Ready is high, so 0xFF is handed over and must vanish.
    i_Valid = 1; i_Data = 8'hB2; i_Ready = 0;
    cycle();
    i_Flush = 1; i_Data = 8'hFF; i_Ready = 1;
    cycle();
    idle();
    total++;
    if (o_Valid !== 0 || o_Occupancy !== 0 || o_Data !== '0) begin
      bad++; $display("FAIL flush_busy: got v=%b occ=%0d d=%h want 0 0 00", o_Valid, o_Occupancy, o_Data);
    end
    cycle(); cycle();
  endtask

  task automatic test_reset_mid();
    i_Ready = 0; i_Valid = 1; i_Data = 8'hC0;
    cycle(); i_Data = 8'hC1;
    cycle();
    reset = 1; idle();
    cycle();
    reset = 0;
    total++;
    if (o_Valid !== 0 || o_Ready !== 1 || o_Data !== '0 || o_Occupancy !== 0 || o_StallCount !== '0) begin
      bad++; $display("FAIL reset_mid: got v=%b r=%b d=%h occ=%0d sc=%0d want 0 1 00 0 0",
                      o_Valid, o_Ready, o_Data, o_Occupancy, o_StallCount);
    end
    i_Ready = 1; i_Valid = 1; i_Data = 8'h5A;
    cycle();
    idle();
    total++;
    if (o_Valid !== 1 || o_Data !== 8'h5A) begin
      bad++; $display("FAIL reset_new: got v=%b d=%h want 1 5a", o_Valid, o_Data);
    end
    cycle();
  endtask

  task automatic test_stall_count();
    int exp;
    reset = 1; i_Ready = 0; idle();
    cycle();
    reset = 0;
    i_Valid = 1; i_Data = 8'hD0;
    cycle();
    idle();
    for (int k = 1; k <= 6; k++) begin
      cycle();
`ifdef ARM_PIPELINED_SKID_STATS_EN
      exp = (k > 3) ? 3 : k;
`else
      exp = 0;
`endif
      total++;
      if (o_StallCount !== SW'(exp)) begin
        bad++; $display("FAIL stall_count[%0d]: got %0d want %0d", k, o_StallCount, exp);
      end
    end
    i_Ready = 1;
    cycle(); cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_stall_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
